a5_keystream_gen: RTL and testbench

A5/1 keystream generator. Accepts a 64-bit session key and 22-bit frame number, runs key/frame loading and 100-cycle majority-clocked mixing, then emits a parameterised number of keystream bits over a valid/ready stream. It drives the serially loaded A5/1 shift registers and delivers keystream to the downstream XOR/packing logic.

---
 rtl/a5_pkg.sv | 33 +++
 rtl/a5_lfsr.sv | 35 +++
 rtl/a5_keystream_gen.sv | 167 ++++++++++++++++
 tb/tb_a5_keystream_gen.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a5_pkg.sv
// rtl/a5_pkg.sv - A5/1 register geometry, phase lengths and FSM states
package a5_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  localparam int KEY_CYCLES   = 64;
  localparam int FRAME_CYCLES = 22;
  localparam int MIX_CYCLES   = 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_KEY,
    ST_FRAME,
    ST_MIX,
    ST_OUT
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_lfsr.sv
// rtl/a5_lfsr.sv - one A5/1 shift register with serial data injection
module a5_lfsr
  import a5_pkg::*;
#(
  parameter int            LEN     = R1_LEN,
  parameter logic [LEN-1:0] TAPS   = R1_TAPS,
  parameter int            CLK_BIT = R1_CLK
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_step,
  input  logic i_d,
  output logic o_msb,
  output logic o_clk_bit
);

  logic [LEN-1:0] r_sr;
  logic           w_fb;

  assign w_fb      = ^(r_sr & TAPS);
  assign o_msb     = r_sr[LEN-1];
  assign o_clk_bit = r_sr[CLK_BIT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_step) begin
      r_sr <= {r_sr[LEN-2:0], i_d ^ w_fb};
    end
  end

endmodule

// File: rtl/a5_keystream_gen.sv
// rtl/a5_keystream_gen.sv - A5/1 key/frame load, majority mixing and
// keystream delivery over a valid/ready bit stream
module a5_keystream_gen
  import a5_pkg::*;
#(
  parameter int OUT_BITS = 228
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [63:0] i_key,
  input  logic [21:0] i_frame,
  output logic        o_busy,
  output logic        o_ks_bit,
  output logic        o_ks_valid,
  input  logic        i_ks_ready,
  output logic        o_ks_last
);

  localparam logic [9:0] LAST_IDX = 10'(OUT_BITS - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [6:0]  r_phase;
  logic [9:0]  r_bit_cnt;
  logic [63:0] r_key;
  logic [21:0] r_frame;
  logic        r_ks_valid;
  logic        r_ks_last;

  logic w_phase_last;
  logic w_hs;
  logic w_produce;
  logic w_load;
  logic w_mstep;
  logic w_maj;
  logic w_d;
  logic w_clr;
  logic w_msb1, w_msb2, w_msb3;
  logic w_cb1, w_cb2, w_cb3;
  logic w_step1, w_step2, w_step3;

  assign w_hs      = r_ks_valid & i_ks_ready;
  // A new bit is produced on the first OUT cycle and on every non-final handshake
  assign w_produce = (r_state == ST_OUT) & (~r_ks_valid | (i_ks_ready & ~r_ks_last));
  assign w_load    = (r_state == ST_KEY) | (r_state == ST_FRAME);
  assign w_mstep   = (r_state == ST_MIX) | w_produce;
  assign w_maj     = maj3(w_cb1, w_cb2, w_cb3);
  assign w_clr     = (r_state == ST_CLR);
  assign w_step1   = w_load | (w_mstep & (w_cb1 == w_maj));
  assign w_step2   = w_load | (w_mstep & (w_cb2 == w_maj));
  assign w_step3   = w_load | (w_mstep & (w_cb3 == w_maj));

  always_comb begin
    w_d = 1'b0;
    if (r_state == ST_KEY) begin
      w_d = r_key[r_phase[5:0]];
    end else if (r_state == ST_FRAME) begin
      w_d = r_frame[r_phase[4:0]];
    end
  end

  always_comb begin
    w_phase_last = 1'b0;
    case (r_state)
      ST_KEY:   w_phase_last = (r_phase == 7'(KEY_CYCLES - 1));
      ST_FRAME: w_phase_last = (r_phase == 7'(FRAME_CYCLES - 1));
      ST_MIX:   w_phase_last = (r_phase == 7'(MIX_CYCLES - 1));
      default:  w_phase_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_CLR;
      ST_CLR:   w_state_nxt = ST_KEY;
      ST_KEY:   if (w_phase_last) w_state_nxt = ST_FRAME;
      ST_FRAME: if (w_phase_last) w_state_nxt = ST_MIX;
      ST_MIX:   if (w_phase_last) w_state_nxt = ST_OUT;
      ST_OUT:   if (w_hs && r_ks_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_key   <= '0;
      r_frame <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_key   <= i_key;
      r_frame <= i_frame;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase <= '0;
    end else if (w_clr || w_phase_last) begin
      r_phase <= '0;
    end else if (w_load || (r_state == ST_MIX)) begin
      r_phase <= r_phase + 7'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bit_cnt  <= '0;
      r_ks_valid <= 1'b0;
      r_ks_last  <= 1'b0;
    end else if (w_clr) begin
      r_bit_cnt  <= '0;
    end else if (w_produce) begin
      r_bit_cnt  <= r_bit_cnt + 10'd1;
      r_ks_valid <= 1'b1;
      r_ks_last  <= (r_bit_cnt == LAST_IDX);
    end else if (w_hs && r_ks_last) begin
      r_ks_valid <= 1'b0;
      r_ks_last  <= 1'b0;
    end
  end

  a5_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .i_clk     (i_clk),
    .i_rst_n   (i_reset_n),
    .i_clr     (w_clr),
    .i_step    (w_step1),
    .i_d       (w_d),
    .o_msb     (w_msb1),
    .o_clk_bit (w_cb1)
  );

  a5_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_reset_n),
    .i_clr     (w_clr),
    .i_step    (w_step2),
    .i_d       (w_d),
    .o_msb     (w_msb2),
    .o_clk_bit (w_cb2)
  );

  a5_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .i_clk     (i_clk),
    .i_rst_n   (i_reset_n),
    .i_clr     (w_clr),
    .i_step    (w_step3),
    .i_d       (w_d),
    .o_msb     (w_msb3),
    .o_clk_bit (w_cb3)
  );

  // Registers only move on a produce step, so their output bit is the held ks_bit
  assign o_ks_bit   = r_ks_valid & (w_msb1 ^ w_msb2 ^ w_msb3);
  assign o_ks_valid = r_ks_valid;
  assign o_ks_last  = r_ks_last;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_a5_keystream_gen.sv
// tb/tb_a5_keystream_gen.sv - scoreboard bench for a5_keystream_gen
module tb_a5_keystream_gen;

  localparam int N = 228;
  localparam logic [18:0] T1 = 19'h72000;
  localparam logic [21:0] T2 = 22'h300000;
  localparam logic [22:0] T3 = 23'h700080;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        busy;
  logic        ks_bit;
  logic        ks_valid;
  logic        ks_ready;
  logic        ks_last;

  logic        start1;
  logic [63:0] key1;
  logic [21:0] frame1;
  logic        busy1;
  logic        ks_bit1;
  logic        ks_valid1;
  logic        ks_ready1;
  logic        ks_last1;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t        exp_q[$];
  logic        model_ks [N];
  logic [119:0] vec_a;
  logic [119:0] vec_b;
  logic [63:0] vkey;
  logic [21:0] vframe;
  int          checks = 0;
  int          failures = 0;
  int          hs_count = 0;
  int          ready_mode = 0;
  int          n;
  int          hs0;
  logic        stall_prev = 1'b0;
  logic        prev_bit;
  logic        prev_last;

  a5_keystream_gen #(.OUT_BITS(N)) u_dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_start    (start),
    .i_key      (key),
    .i_frame    (frame),
    .o_busy     (busy),
    .o_ks_bit   (ks_bit),
    .o_ks_valid (ks_valid),
    .i_ks_ready (ks_ready),
    .o_ks_last  (ks_last)
  );

  a5_keystream_gen #(.OUT_BITS(1)) u_dut1 (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_start    (start1),
    .i_key      (key1),
    .i_frame    (frame1),
    .o_busy     (busy1),
    .o_ks_bit   (ks_bit1),
    .o_ks_valid (ks_valid1),
    .i_ks_ready (ks_ready1),
    .o_ks_last  (ks_last1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic vec_bit(input int i);
    return (i < 114) ? vec_a[119 - i] : vec_b[233 - i];
  endfunction

  // Reference: straight A5/1 algorithm on plain bit vectors
  task automatic model_run(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic        d;
    logic        m;
    a = '0;
    b = '0;
    c = '0;
    for (int i = 0; i < 86; i++) begin
      d = (i < 64) ? k[i] : f[i - 64];
      a = {a[17:0], d ^ (^(a & T1))};
      b = {b[20:0], d ^ (^(b & T2))};
      c = {c[21:0], d ^ (^(c & T3))};
    end
    for (int i = 0; i < 100 + N; i++) begin
      m = ((int'(a[8]) + int'(b[10]) + int'(c[10])) >= 2);
      if (a[8] == m) a = {a[17:0], ^(a & T1)};
      if (b[10] == m) b = {b[20:0], ^(b & T2)};
      if (c[10] == m) c = {c[21:0], ^(c & T3)};
      if (i >= 100) model_ks[i - 100] = a[18] ^ b[21] ^ c[22];
    end
  endtask

  task automatic push_vec();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.b    = vec_bit(i);
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_model(input logic [63:0] k, input logic [21:0] f);
    exp_t e;
    model_run(k, f);
    for (int i = 0; i < N; i++) begin
      e.b    = model_ks[i];
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    while (busy && cyc < bound) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", cyc);
    end
  endtask

  task automatic end_of_run(input string name, input int hs_exp);
    chk1({name, "_valid_low"}, ks_valid, 1'b0);
    chk32({name, "_handshakes"}, hs_count - hs0, hs_exp);
    chk32({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", ks_valid, 1'b0);
    chk1("rst_bit", ks_bit, 1'b0);
    chk1("rst_last", ks_last, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("post_rst_valid", ks_valid, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);
  endtask

  task automatic run_dut1(input logic [63:0] k, input logic [21:0] f);
    model_run(k, f);
    key1   = k;
    frame1 = f;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    n = 0;
    while (!ks_valid1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk32("ob1_latency", n, 188);
    chk1("ob1_bit", ks_bit1, model_ks[0]);
    chk1("ob1_last", ks_last1, 1'b1);
    chk1("ob1_busy", busy1, 1'b1);
    @(posedge clk);
    #1;
    chk1("ob1_valid_drop", ks_valid1, 1'b0);
    chk1("ob1_busy_drop", busy1, 1'b0);
  endtask

  initial begin
    ks_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ks_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk1("stall_valid", ks_valid, 1'b1);
          chk1("stall_bit", ks_bit, prev_bit);
          chk1("stall_last", ks_last, prev_last);
        end
        if (ks_valid && ks_ready) begin
          hs_count++;
          chk1("hs_busy", busy, 1'b1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bit: handshake %0d with empty scoreboard", hs_count);
          end else begin
            e = exp_q.pop_front();
            chk1("ks_bit", ks_bit, e.b);
            chk1("ks_last", ks_last, e.last);
          end
        end
        stall_prev = ks_valid && !ks_ready;
        prev_bit   = ks_bit;
        prev_last  = ks_last;
      end
    end
  end

  initial begin
    vec_a  = 120'h534EAA582FE8151AB6E1855A728C00;
    vec_b  = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    vkey   = 64'hEFCDAB8967452312;
    vframe = 22'h134;
    reset_n = 1'b0;
    start   = 1'b0;
    key     = '0;
    frame   = '0;
    start1  = 1'b0;
    key1    = '0;
    frame1  = '0;
    ks_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_valid", ks_valid, 1'b0);
    chk1("reset_bit", ks_bit, 1'b0);
    chk1("reset_last", ks_last, 1'b0);
    chk1("reset_valid1", ks_valid1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reference vector, ready tied high: latency and back-to-back burst
    key = vkey;
    frame = vframe;
    ready_mode = 0;
    hs0 = hs_count;
    push_vec();
    do_start();
    key = '0;
    frame = '0;
    chk1("busy_after_e0", busy, 1'b1);
    n = 0;
    while (!ks_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk32("latency", n, 188);
    wait_idle(1000, n);
    chk32("burst_cycles", n, N);
    end_of_run("run1", N);

    // Same vector under random backpressure
    key = vkey;
    frame = vframe;
    ready_mode = 1;
    hs0 = hs_count;
    push_vec();
    do_start();
    wait_idle(5000, n);
    end_of_run("stall", N);

    // start pulses during MIX and OUT are ignored
    hs0 = hs_count;
    push_vec();
    do_start();
    repeat (120) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!ks_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(5000, n);
    end_of_run("ignore_start", N);
    repeat (3) @(posedge clk);
    #1;
    chk1("no_restart", busy, 1'b0);

    // start held across the end of a run starts a second identical run
    ready_mode = 0;
    hs0 = hs_count;
    push_vec();
    push_vec();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk1("held_busy", busy, 1'b1);
    wait_idle(1000, n);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk1("held_restart", busy, 1'b1);
    wait_idle(1000, n);
    end_of_run("held", 2 * N);

    // Reset during KEY, then during OUT, then a clean run
    ready_mode = 1;
    do_start();
    repeat (30) @(posedge clk);
    pulse_reset();
    push_vec();
    do_start();
    n = 0;
    while (hs_count < hs0 + 2 * N + 50 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1("out_reached", ks_valid, 1'b1);
    pulse_reset();
    hs0 = hs_count;
    push_vec();
    do_start();
    wait_idle(5000, n);
    end_of_run("after_reset", N);

    // Random keys and frames against the reference model
    for (int r = 0; r < 3; r++) begin
      key = {$urandom(), $urandom()};
      frame = 22'($urandom());
      hs0 = hs_count;
      push_model(key, frame);
      do_start();
      key = ~key;
      wait_idle(5000, n);
      end_of_run("random", N);
    end

    // Single-bit build
    run_dut1(vkey, vframe);
    run_dut1({$urandom(), $urandom()}, 22'($urandom()));

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
